// File: rtl/status_flag_bank_pkg.sv
// Shared field positions, default geometry and the saved-context entry type
// for the processor status register and its shadow stack.
package status_flag_bank_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NUM_FLAGS   = 4;
  localparam int DEF_MODE_BITS   = 1;
  localparam int DEF_STACK_DEPTH = 4;

  localparam int FLAG_LSB    = DEF_WIDTH - DEF_NUM_FLAGS;
  localparam int STK_ERR_BIT = DEF_MODE_BITS;

  localparam logic [DEF_MODE_BITS-1:0] DEF_PRIV_MODE = '1;

  typedef struct packed {
    logic [DEF_NUM_FLAGS-1:0] flags;
    logic [DEF_MODE_BITS-1:0] mode;
  } status_entry_t;

  function automatic int flag_lsb(input int width, input int num_flags);
    return width - num_flags;
  endfunction

endpackage

// File: rtl/status_flag_bank_shadow_stack.sv
// Parametrised LIFO holding saved {flags,mode} contexts; it only saturates,
// reporting of overflow/underflow is left to the owner.
module status_flag_bank_shadow_stack #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 5,
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] pop_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [2**IDX_W];
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign full   = (level == LEVEL_W'(DEPTH));
  assign empty  = (level == '0);
  assign wr_idx = IDX_W'(level);
  assign rd_idx = IDX_W'(level - LEVEL_W'(1));

  // Push wins over pop when both are requested; the owner normally masks pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      level       <= level + LEVEL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LEVEL_W'(1);
    end
  end

  always_comb begin
    pop_data = '0;
    if (!empty) pop_data = mem[rd_idx];
  end

endmodule

// File: rtl/status_flag_bank.sv
// Processor status register: condition flags with per-flag enables and sticky
// bits, a mode field, and a shadow stack saving context across exceptions.
module status_flag_bank
  import status_flag_bank_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
  parameter int MODE_BITS   = DEF_MODE_BITS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [NUM_FLAGS-1:0] STICKY_MASK = '0,
  parameter logic [MODE_BITS-1:0] PRIV_MODE   = '1,
  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FLAGS-1:0] clr_flag,
  input  logic [NUM_FLAGS-1:0] flag_we,
  input  logic [NUM_FLAGS-1:0] flag_val,
  input  logic                 csr_we,
  input  logic [WIDTH-1:0]     csr_wdata,
  input  logic                 exc_enter,
  input  logic                 exc_return,
  output logic [WIDTH-1:0]     status_reg,
  output logic [MODE_BITS-1:0] mode,
  output logic [LEVEL_W-1:0]   stack_level,
  output logic                 stack_full,
  output logic                 stack_empty
);

  localparam int ENTRY_W  = NUM_FLAGS + MODE_BITS;
  localparam int FLAG_POS = flag_lsb(WIDTH, NUM_FLAGS);

  logic [NUM_FLAGS-1:0] flags_q, flags_d, flags_upd;
  logic [MODE_BITS-1:0] mode_q, mode_d;
  logic                 stk_err_q, stk_err_d;
  logic                 push, pop;
  logic [ENTRY_W-1:0]   pop_data;
  logic                 unused_csr_bits;

  assign unused_csr_bits = ^csr_wdata;

  // Return is dropped when entry happens in the same cycle.
  assign push = exc_enter;
  assign pop  = exc_return && !exc_enter;

  status_flag_bank_shadow_stack #(
    .DEPTH  (STACK_DEPTH),
    .ENTRY_W(ENTRY_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data({flags_q, mode_q}),
    .pop_data (pop_data),
    .level    (stack_level),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  always_comb begin
    flags_upd = flags_q;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (clr_flag[i])          flags_upd[i] = 1'b0;
      else if (flag_we[i])      flags_upd[i] = STICKY_MASK[i] ? (flags_q[i] | flag_val[i]) : flag_val[i];
    end
  end

  always_comb begin
    flags_d   = flags_q;
    mode_d    = mode_q;
    stk_err_d = stk_err_q;
    if (exc_enter) begin
      if (stack_full) stk_err_d = 1'b1;
      flags_d = flags_upd;
      mode_d  = PRIV_MODE;
    end else if (exc_return) begin
      if (stack_empty) stk_err_d = 1'b1;
      else             {flags_d, mode_d} = pop_data;
    end else if (csr_we) begin
      flags_d = csr_wdata[WIDTH-1 -: NUM_FLAGS];
      mode_d  = csr_wdata[MODE_BITS-1:0];
      if (!csr_wdata[MODE_BITS]) stk_err_d = 1'b0;
    end else begin
      flags_d = flags_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= '0;
      mode_q    <= '0;
      stk_err_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      mode_q    <= mode_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_comb begin
    status_reg                               = '0;
    status_reg[FLAG_POS +: NUM_FLAGS]        = flags_q;
    status_reg[MODE_BITS]                    = stk_err_q;
    status_reg[MODE_BITS-1:0]                = mode_q;
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_status_flag_bank.sv
// Scoreboard bench for status_flag_bank: a behavioural model predicts each
// cycle's outputs, queued at drive time and compared after the clock edge.
module tb_status_flag_bank;
  import status_flag_bank_pkg::*;

  localparam logic [3:0] STICKY = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  clr_flag, flag_we, flag_val;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        exc_enter, exc_return;
  logic [31:0] status_reg;
  logic [0:0]  mode;
  logic [2:0]  stack_level;
  logic        stack_full, stack_empty;

  typedef struct {
    logic [31:0] status;
    logic [31:0] mode;
    logic [31:0] level;
    logic [31:0] full;
    logic [31:0] empty;
  } exp_t;

  exp_t          exp_q[$];
  status_entry_t m_stack[$];
  logic [3:0]    m_flags;
  logic [0:0]    m_mode;
  logic          m_err;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  status_flag_bank #(
    .STICKY_MASK(STICKY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_flag   (clr_flag),
    .flag_we    (flag_we),
    .flag_val   (flag_val),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .exc_enter  (exc_enter),
    .exc_return (exc_return),
    .status_reg (status_reg),
    .mode       (mode),
    .stack_level(stack_level),
    .stack_full (stack_full),
    .stack_empty(stack_empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] model_update(input logic [3:0] f, input logic [3:0] clr,
                                              input logic [3:0] we, input logic [3:0] val);
    logic [3:0] r;
    r = f;
    for (int i = 0; i < 4; i++)
      if (clr[i])     r[i] = 1'b0;
      else if (we[i]) r[i] = STICKY[i] ? (f[i] | val[i]) : val[i];
    return r;
  endfunction

  // Drive one cycle, advance the model, then compare the DUT after the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] clr, input logic [3:0] we,
                               input logic [3:0] val, input logic cw, input logic [31:0] cd,
                               input logic en, input logic ret);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; clr_flag = clr; flag_we = we; flag_val = val;
    csr_we = cw; csr_wdata = cd; exc_enter = en; exc_return = ret;
    if (r) begin
      m_flags = '0; m_mode = '0; m_err = 1'b0; m_stack.delete();
    end else if (en) begin
      if (m_stack.size() < 4) m_stack.push_back('{flags: m_flags, mode: m_mode});
      else                    m_err = 1'b1;
      m_flags = model_update(m_flags, clr, we, val);
      m_mode  = DEF_PRIV_MODE;
    end else if (ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin
        status_entry_t s;
        s = m_stack.pop_back();
        m_flags = s.flags; m_mode = s.mode;
      end
    end else if (cw) begin
      m_flags = cd[31:28];
      m_mode  = cd[0];
      if (!cd[STK_ERR_BIT]) m_err = 1'b0;
    end else begin
      m_flags = model_update(m_flags, clr, we, val);
    end
    e.status = {m_flags, 26'b0, m_err, m_mode};
    e.mode   = 32'(m_mode);
    e.level  = 32'(m_stack.size());
    e.full   = 32'(m_stack.size() == 4);
    e.empty  = 32'(m_stack.size() == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checkOutput("status_reg",  status_reg,        got.status);
    checkOutput("mode",        32'(mode),         got.mode);
    checkOutput("stack_level", 32'(stack_level),  got.level);
    checkOutput("stack_full",  32'(stack_full),   got.full);
    checkOutput("stack_empty", 32'(stack_empty),  got.empty);
  endtask

  task automatic idle();
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; clr_flag = '0; flag_we = '0; flag_val = '0;
    csr_we = 1'b0; csr_wdata = '0; exc_enter = 1'b0; exc_return = 1'b0;
    m_flags = '0; m_mode = '0; m_err = 1'b0;

    $display("[TB] reset with every input asserted");
    applyStimulus(1, 4'hF, 4'hF, 4'hF, 1, 32'hFFFF_FFFF, 1, 1);
    idle();

    $display("[TB] sticky and plain flag updates");
    applyStimulus(0, 4'h0, 4'hF, 4'hF, 0, 32'h0, 0, 0);
    applyStimulus(0, 4'h0, 4'hF, 4'h0, 0, 32'h0, 0, 0);
    applyStimulus(0, 4'h8, 4'h0, 4'h0, 0, 32'h0, 0, 0);

    $display("[TB] exception entry and return restore context");
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 32'h5000_0002, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 1, 0);
    applyStimulus(0, 4'h0, 4'hF, 4'hF, 0, 32'h0, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 0, 1);

    $display("[TB] overflow sets error, csr write clears it");
    for (int i = 0; i < 5; i++) applyStimulus(0, 4'h0, 4'h1, 4'(i), 0, 32'h0, 1, 0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 32'h3000_0000, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'h0, 4'hF, 4'h0, 1, 32'hA000_0003, 0, 1);

    $display("[TB] underflow and simultaneous enter/return");
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 32'h6000_0001, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 0, 1);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 1, 32'h6000_0000, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 1, 1);
    applyStimulus(0, 4'h0, 4'h0, 4'h0, 0, 32'h0, 0, 1);

    $display("[TB] clear beats write, csr beats flag write");
    applyStimulus(0, 4'h0, 4'h1, 4'h1, 0, 32'h0, 0, 0);
    applyStimulus(0, 4'h1, 4'h1, 4'h1, 0, 32'h0, 0, 0);
    applyStimulus(0, 4'h0, 4'hF, 4'hF, 1, 32'h2000_0000, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 29) == 0),
                    4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    4'($urandom), 4'($urandom),
                    ($urandom_range(0, 9) == 0), $urandom,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
